mips_fetch_stage: RTL

- Instruction-fetch stage directly upstream of the control unit.
- Owns the PC register and requests instructions from an instruction memory with variable latency.
- Holds the fetched word stable and presents op_code/funct to the control unit and the rest of the decoder.
- Computes the next PC from the branch/jump decisions fed back by the datapath.

---
 rtl/mips_pkg.sv | 11 +
 rtl/mips_next_pc.sv | 25 ++
 rtl/mips_fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and instruction-field positions for the MIPS front end.
package mips_pkg;
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERROR} fetch_state_t;

   localparam logic [5:0] OPCODE_J = 6'b000010;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int JADDR_MSB = 25;
endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jump > taken branch > sequential.
module mips_next_pc
   import mips_pkg::*;
(
   input  logic [31:0]        pc_plus4,
   input  logic [JADDR_MSB:0] jaddr,
   input  logic               branch_taken,
   input  logic [31:0]        branch_imm,
   input  logic               jump,
   output logic [31:0]        next_pc
);
   logic [31:0] branch_target;

   // Shift drops branch_imm[31:30]; the add wraps modulo 2^32.
   assign branch_target = pc_plus4 + (branch_imm << 2);

   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], jaddr, 2'b00};
      end else if (branch_taken) begin
         next_pc = branch_target;
      end
   end
endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction fetch: PC register, one outstanding imem request, and an
// instruction register held stable for the decoder until acknowledged.
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op_code,
   output logic [5:0]  funct,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic        branch_taken,
   input  logic [31:0] branch_imm,
   input  logic        jump,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   fetch_state_t     state;
   fetch_state_t     state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      next_pc;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign op_code   = instr[OP_MSB:OP_LSB];
   assign funct     = instr[FUNCT_MSB:0];

   mips_next_pc u_next_pc (
      .pc_plus4     (pc_plus4),
      .jaddr        (instr[JADDR_MSB:0]),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .next_pc      (next_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // imem_req is decoded from state so an async reset drops it immediately.
   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      unique case (state)
         BOOT: state_nxt = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_rvalid) begin
               state_nxt = HOLD;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERROR;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (instr_ack) begin
               state_nxt = FETCH;
            end
         end
         ERROR: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         instr     <= 32'h0;
         cnt       <= '0;
         fetch_err <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_rvalid) begin
                  instr <= imem_rdata;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  fetch_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HOLD: begin
               if (instr_ack) begin
                  pc <= next_pc;
               end
            end
            BOOT, ERROR: ;
         endcase
      end
   end
endmodule
